mips_cpu_divider: RTL and testbench

//  Multi-cycle iterative divider for DIV/DIVU. Sits upstream of the ALU Hi/Lo registers:

---
 rtl/mips_cpu_pkg.sv | 14 +
 rtl/mips_cpu_div_step.sv | 25 ++
 rtl/mips_cpu_divider.sv | 170 +++++++++++++++++
 tb/tb_mips_cpu_divider.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS CPU divider slice.
package mips_cpu_pkg;

   localparam int unsigned DIV_WIDTH = 32;

   typedef enum logic [2:0] {
      StIdle,
      StPrep,
      StIter,
      StFix,
      StDone
   } div_state_t;

endpackage

// File: rtl/mips_cpu_div_step.sv
// One restoring shift-subtract step: shifts {rem,quo} left by one and
// subtracts the divisor from the partial remainder when it fits.
module mips_cpu_div_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic [WIDTH:0]   w_shift;
   logic             w_ge;
   logic [WIDTH-1:0] w_diff;

   // Shifted remainder needs one extra bit before the compare.
   assign w_shift = {i_rem, i_quo[WIDTH-1]};
   assign w_ge    = (w_shift >= {1'b0, i_divisor});
   assign w_diff  = w_shift[WIDTH-1:0] - i_divisor;

   assign o_rem = w_ge ? w_diff : w_shift[WIDTH-1:0];
   assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/mips_cpu_divider.sv
// Multi-cycle restoring divider for DIV/DIVU feeding Hi/Lo.
// Define DIV_FAST_ZERO_EN to short-circuit a zero divisor straight from PREP to DONE.
module mips_cpu_divider
   import mips_cpu_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_is_signed,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   div_state_t       r_state;
   logic [CNT_W-1:0] r_count;
   logic             r_signed;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_div_zero;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;

   logic [WIDTH-1:0] w_rem_step;
   logic [WIDTH-1:0] w_quo_step;
   logic [WIDTH-1:0] w_fix_q;
   logic [WIDTH-1:0] w_fix_r;
   logic             w_last;

   function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v, input logic s);
      return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

   mips_cpu_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_rem     (r_rem),
      .i_quo     (r_quo),
      .i_divisor (r_div),
      .o_rem     (w_rem_step),
      .o_quo     (w_quo_step)
   );

   assign w_last = (r_count == CNT_W'(WIDTH - 1));

   // A zero divisor always reports all-ones / raw dividend, whatever ITER produced.
   assign w_fix_q = r_div_zero ? '1  : (r_neg_q ? (~r_quo + 1'b1) : r_quo);
   assign w_fix_r = r_div_zero ? r_a : (r_neg_r ? (~r_rem + 1'b1) : r_rem);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_count     <= '0;
         r_signed    <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_div       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_div_zero  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_done <= 1'b0;
               // A simultaneous flush squashes the request.
               if (i_start && !i_flush) begin
                  r_a      <= i_dividend;
                  r_b      <= i_divisor;
                  r_signed <= i_is_signed;
                  r_busy   <= 1'b1;
                  r_state  <= StPrep;
               end
            end
            StPrep: begin
               if (i_flush) begin
                  r_busy  <= 1'b0;
                  r_state <= StIdle;
               end else begin
                  r_div_zero <= (r_b == '0);
                  r_neg_q    <= r_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                  r_neg_r    <= r_signed && r_a[WIDTH-1];
`ifdef DIV_FAST_ZERO_EN
                  if (r_b == '0) begin
                     r_quotient  <= '1;
                     r_remainder <= r_a;
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                     r_state     <= StDone;
                  end else begin
                     r_quo   <= f_abs(r_a, r_signed);
                     r_div   <= f_abs(r_b, r_signed);
                     r_rem   <= '0;
                     r_count <= '0;
                     r_state <= StIter;
                  end
`else
                  r_quo   <= f_abs(r_a, r_signed);
                  r_div   <= f_abs(r_b, r_signed);
                  r_rem   <= '0;
                  r_count <= '0;
                  r_state <= StIter;
`endif
               end
            end
            StIter: begin
               if (i_flush) begin
                  r_busy  <= 1'b0;
                  r_state <= StIdle;
               end else begin
                  r_rem   <= w_rem_step;
                  r_quo   <= w_quo_step;
                  r_count <= r_count + 1'b1;
                  if (w_last) begin
                     r_state <= StFix;
                  end
               end
            end
            StFix: begin
               if (i_flush) begin
                  r_busy  <= 1'b0;
                  r_state <= StIdle;
               end else begin
                  r_quotient  <= w_fix_q;
                  r_remainder <= w_fix_r;
                  r_busy      <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= StDone;
               end
            end
            StDone: begin
               // start and flush are both ignored here.
               r_done  <= 1'b0;
               r_state <= StIdle;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_quotient  = r_quotient;
   assign o_remainder = r_remainder;

endmodule

// File: tb/tb_mips_cpu_divider.sv
// Scoreboard bench for mips_cpu_divider: directed DIV/DIVU vectors, flush, reset and start hazards.
module tb_mips_cpu_divider;

   localparam int W = 32;
   localparam int LAT = 35;
`ifdef DIV_FAST_ZERO_EN
   localparam int ZLAT = 2;
`else
   localparam int ZLAT = 35;
`endif

   logic         i_clk = 1'b0;
   logic         i_rst_n;
   logic         i_start;
   logic         i_is_signed;
   logic         i_flush;
   logic [W-1:0] i_dividend;
   logic [W-1:0] i_divisor;
   logic         o_busy;
   logic         o_done;
   logic [W-1:0] o_quotient;
   logic [W-1:0] o_remainder;

   int n_tests = 0;
   int n_fail  = 0;
   int n_done  = 0;
   logic [2*W-1:0] exp_q[$];

   mips_cpu_divider #(
      .WIDTH (W)
   ) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .i_is_signed (i_is_signed),
      .i_flush     (i_flush),
      .i_dividend  (i_dividend),
      .i_divisor   (i_divisor),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_quotient  (o_quotient),
      .o_remainder (o_remainder)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest expected result.
   initial begin
      forever begin
         @(negedge i_clk);
         if (i_rst_n === 1'b1 && o_done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: got q=%h r=%h expected no done", o_quotient,
                        o_remainder);
            end else begin
               check("result", {o_quotient, o_remainder}, exp_q.pop_front());
            end
         end
      end
   end

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      i_dividend  = a;
      i_divisor   = b;
      i_is_signed = s;
      i_start     = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
   endtask

   // Counts cycles (cycle 1 = first cycle after the accepting edge) until done.
   task automatic wait_done(input string name, input int lat, input int cyc0);
      int cyc = cyc0 - 1;
      int busy_err = 0;
      bit seen = 1'b0;
      while (!seen && cyc < 100) begin
         @(negedge i_clk);
         cyc++;
         if (o_busy !== (cyc < lat)) busy_err++;
         if (o_done === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: got no done after %0d cycles expected done at %0d", name, cyc,
                  lat);
      end else begin
         check({name, "_latency"}, 64'(cyc), 64'(lat));
         check({name, "_busy"}, 64'(busy_err), 64'd0);
      end
   endtask

   task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] q, input logic [W-1:0] r,
                        input int lat);
      exp_q.push_back({q, r});
      start_op(a, b, s);
      wait_done(name, lat, 1);
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      int nd;
      i_rst_n     = 1'b0;
      i_start     = 1'b0;
      i_is_signed = 1'b0;
      i_flush     = 1'b0;
      i_dividend  = '0;
      i_divisor   = '0;
      repeat (3) @(posedge i_clk);
      #1;
      check("reset_busy", 64'(o_busy), 64'd0);
      check("reset_done", 64'(o_done), 64'd0);
      check("reset_result", {o_quotient, o_remainder}, 64'd0);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      do_op("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, LAT);
      do_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, LAT);
      do_op("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, LAT);
      do_op("div_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, LAT);
      do_op("divu_min_max", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, LAT);
      do_op("divu_5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, ZLAT);
      do_op("div_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, ZLAT);
      do_op("div_m100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, LAT);
      do_op("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, LAT);

      // start raised during DONE is ignored and taken on the following IDLE edge.
      exp_q.push_back({32'd100, 32'd0});
      start_op(32'd1000, 32'd10, 1'b0);
      wait_done("divu_1000_10", LAT, 1);
      exp_q.push_back({32'd1234, 32'd567});
      i_dividend  = 32'd1234567;
      i_divisor   = 32'd1000;
      i_is_signed = 1'b0;
      i_start     = 1'b1;
      @(posedge i_clk);
      #1;
      check("start_in_done_ignored", 64'(o_busy), 64'd0);
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      check("start_after_done_taken", 64'(o_busy), 64'd1);
      wait_done("divu_1234567_1000", LAT, 1);
      @(posedge i_clk);
      #1;

      // Flush mid-iteration: no done, result registers keep the previous answer.
      nd = n_done;
      start_op(32'd100, 32'd7, 1'b0);
      repeat (8) @(posedge i_clk);
      #1;
      i_flush = 1'b1;
      @(posedge i_clk);
      #1;
      i_flush = 1'b0;
      check("flush_busy", 64'(o_busy), 64'd0);
      check("flush_keeps_result", {o_quotient, o_remainder}, {32'd1234, 32'd567});
      do_op("after_flush", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, LAT);
      check("flush_single_done", 64'(n_done - nd), 64'd1);

      // Second start mid-operation is dropped.
      nd = n_done;
      exp_q.push_back({32'd100, 32'd0});
      start_op(32'd1000, 32'd10, 1'b0);
      repeat (4) @(posedge i_clk);
      #1;
      start_op(32'd9, 32'd3, 1'b0);
      wait_done("double_start", LAT, 6);
      repeat (40) @(posedge i_clk);
      #1;
      check("double_start_one_done", 64'(n_done - nd), 64'd1);

      // flush together with start in IDLE drops the request.
      nd = n_done;
      i_dividend = 32'd50;
      i_divisor  = 32'd5;
      i_start    = 1'b1;
      i_flush    = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      i_flush = 1'b0;
      check("flush_start_idle_busy", 64'(o_busy), 64'd0);
      repeat (40) @(posedge i_clk);
      #1;
      check("flush_start_idle_no_done", 64'(n_done - nd), 64'd0);

      // Asynchronous reset mid-operation.
      nd = n_done;
      start_op(32'd100, 32'd7, 1'b0);
      repeat (18) @(posedge i_clk);
      #3;
      i_rst_n = 1'b0;
      #1;
      check("midop_reset_busy_done", {62'd0, o_busy, o_done}, 64'd0);
      check("midop_reset_result", {o_quotient, o_remainder}, 64'd0);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      repeat (40) @(posedge i_clk);
      #1;
      check("midop_reset_no_done", 64'(n_done - nd), 64'd0);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
